// File: rtl/pc_stack.sv
// Hack-style program counter (load / inc / reset) with a hardware call/return stack.
// Define PC_STACK_WRAP_EN to make the return stack circular instead of erroring on overflow.
module pc_stack #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       inc_i,
    input  logic                       load_i,
    input  logic                       call_i,
    input  logic                       ret_i,
    input  logic [WIDTH-1:0]           addr_i,
    input  logic                       clr_err_i,
    output logic [WIDTH-1:0]           out_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       err_o
);

    localparam int               DW         = $clog2(DEPTH + 1);
    localparam int               AW         = $clog2(DEPTH);
    localparam logic [DW-1:0]    DEPTH_FULL = DW'(DEPTH);

    typedef enum logic [2:0] {
        CMD_HOLD     = 3'd0,
        CMD_INC      = 3'd1,
        CMD_LOAD     = 3'd2,
        CMD_CALL     = 3'd3,
        CMD_RET      = 3'd4,
        CMD_CONFLICT = 3'd5
    } cmd_t;

    cmd_t             cmd_s;
    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [DW-1:0]    depth_r;
    logic [DW-1:0]    depth_nxt_s;
    logic [AW-1:0]    ptr_r;
    logic [AW-1:0]    ptr_nxt_s;
    logic [AW-1:0]    top_idx_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             err_set_s;
    logic             push_s;
    logic             full_s;
    logic             empty_s;

    // ptr_r is the next free slot; the top entry sits one below it (mod DEPTH).
    assign ret_addr_s = pc_r + WIDTH'(1);
    assign top_idx_s  = ptr_r - AW'(1);
    assign full_s     = (depth_r == DEPTH_FULL);
    assign empty_s    = (depth_r == {DW{1'b0}});

    // Fixed-priority command decode.
    always_comb begin
        cmd_s = CMD_HOLD;
        if (call_i && ret_i) begin
            cmd_s = CMD_CONFLICT;
        end else if (ret_i) begin
            cmd_s = CMD_RET;
        end else if (call_i) begin
            cmd_s = CMD_CALL;
        end else if (load_i) begin
            cmd_s = CMD_LOAD;
        end else if (inc_i) begin
            cmd_s = CMD_INC;
        end else begin
            cmd_s = CMD_HOLD;
        end
    end

    // Next-state computation for PC, stack pointer, depth and error flag.
    always_comb begin
        pc_nxt_s    = pc_r;
        depth_nxt_s = depth_r;
        ptr_nxt_s   = ptr_r;
        err_set_s   = 1'b0;
        push_s      = 1'b0;
        case (cmd_s)
            CMD_CONFLICT: begin
                err_set_s = 1'b1;
            end
            CMD_RET: begin
                if (empty_s) begin
                    err_set_s = 1'b1;
                end else begin
                    pc_nxt_s    = stack_r[top_idx_s];
                    depth_nxt_s = depth_r - DW'(1);
                    ptr_nxt_s   = top_idx_s;
                end
            end
            CMD_CALL: begin
                if (!full_s) begin
                    push_s      = 1'b1;
                    pc_nxt_s    = addr_i;
                    depth_nxt_s = depth_r + DW'(1);
                    ptr_nxt_s   = ptr_r + AW'(1);
                end else begin
`ifdef PC_STACK_WRAP_EN
                    // Full ring: ptr_r points at the oldest entry, overwrite it.
                    push_s    = 1'b1;
                    pc_nxt_s  = addr_i;
                    ptr_nxt_s = ptr_r + AW'(1);
`else
                    err_set_s = 1'b1;
`endif
                end
            end
            CMD_LOAD: begin
                pc_nxt_s = addr_i;
            end
            CMD_INC: begin
                pc_nxt_s = ret_addr_s;
            end
            CMD_HOLD: begin
                pc_nxt_s = pc_r;
            end
            default: begin
                pc_nxt_s = pc_r;
            end
        endcase

        // A new error in the same cycle as a clear leaves the flag set.
        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (clr_err_i) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_r    <= RESET_ADDR;
            depth_r <= {DW{1'b0}};
            ptr_r   <= {AW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            depth_r <= depth_nxt_s;
            ptr_r   <= ptr_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Return-address storage; deliberately not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            stack_r[ptr_r] <= ret_addr_s;
        end
    end

    assign out_o   = pc_r;
    assign depth_o = depth_r;
    assign err_o   = err_r;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus random commands against a queue model.
module tb_pc_stack;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc = 1'b0;
    logic        load = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] out;
    logic [3:0]  depth;
    logic        full;
    logic        empty;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_q[$];
    logic        m_err = 1'b0;

    pc_stack #(.WIDTH(16), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .load_i(load), .call_i(call),
        .ret_i(ret), .addr_i(addr), .clr_err_i(clr), .out_o(out),
        .depth_o(depth), .full_o(full), .empty_o(empty), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},   {16'h0000, out},      {16'h0000, m_pc});
        check({tag, ".depth"}, {28'h0, depth},       m_q.size());
        check({tag, ".full"},  {31'h0, full},        {31'h0, (m_q.size() == DEPTH)});
        check({tag, ".empty"}, {31'h0, empty},       {31'h0, (m_q.size() == 0)});
        check({tag, ".err"},   {31'h0, err},         {31'h0, m_err});
    endtask

    // Reference behaviour: a bounded LIFO of return addresses.
    task automatic model_apply(input logic c, input logic r, input logic l, input logic i,
                               input logic [15:0] a, input logic cl);
        logic        set_err;
        logic [15:0] tmp;
        set_err = 1'b0;
        if (c && r) begin
            set_err = 1'b1;
        end else if (r) begin
            if (m_q.size() == 0) set_err = 1'b1;
            else m_pc = m_q.pop_back();
        end else if (c) begin
            tmp = m_pc + 16'd1;
            if (m_q.size() < DEPTH) begin
                m_q.push_back(tmp);
                m_pc = a;
            end else begin
`ifdef PC_STACK_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(tmp);
                m_pc = a;
`else
                set_err = 1'b1;
`endif
            end
        end else if (l) begin
            m_pc = a;
        end else if (i) begin
            m_pc = m_pc + 16'd1;
        end
        if (set_err) m_err = 1'b1;
        else if (cl) m_err = 1'b0;
    endtask

    task automatic step(input string tag, input logic c, input logic r, input logic l,
                        input logic i, input logic [15:0] a, input logic cl);
        call = c; ret = r; load = l; inc = i; addr = a; clr = cl;
        @(posedge clk);
        #1;
        model_apply(c, r, l, i, a, cl);
        call = 1'b0; ret = 1'b0; load = 1'b0; inc = 1'b0; clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] held;
        // Reset state, visible before any clock edge.
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 5; k++) step("inc5", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        check("inc5.const", {16'h0, out}, 32'h5);

        // Nested call/return.
        step("load10", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0);
        step("call100", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0);
        step("inc_a", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step("inc_b", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step("call200", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0);
        check("call200.depth", {28'h0, depth}, 32'd2);
        step("ret1", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("ret1.const", {16'h0, out}, 32'h0103);
        step("ret2", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("ret2.const", {16'h0, out}, 32'h0011);

        // Modulo return address and increment wrap.
        step("loadffff", 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        step("call40", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0);
        step("ret_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("ret_wrap.const", {16'h0, out}, 32'h0000);
        step("loadffff2", 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        step("inc_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        check("inc_wrap.const", {16'h0, out}, 32'h0000);

        // Fill, then overflow.
        for (int k = 0; k < DEPTH; k++) begin
            a = 16'($urandom);
            step("fill", 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b0);
        end
        check("fill.full", {31'h0, full}, 32'd1);
        held = out;
        step("ovf", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0ABC, 1'b0);
`ifdef PC_STACK_WRAP_EN
        check("ovf.out", {16'h0, out}, 32'h0ABC);
        check("ovf.err", {31'h0, err}, 32'd0);
`else
        check("ovf.out", {16'h0, out}, {16'h0, held});
        check("ovf.err", {31'h0, err}, 32'd1);
`endif
        check("ovf.depth", {28'h0, depth}, 32'd8);
        step("ovf_clr", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < DEPTH; k++) step("drain", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Underflow, clear, conflicts.
        held = out;
        step("udf", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("udf.err", {31'h0, err}, 32'd1);
        check("udf.out", {16'h0, out}, {16'h0, held});
        step("clr", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("clr.err", {31'h0, err}, 32'd0);
        step("call_ret", 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0);
        check("call_ret.err", {31'h0, err}, 32'd1);
        step("clr_vs_set", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("clr_vs_set.err", {31'h0, err}, 32'd1);
        step("load_inc", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0033, 1'b1);
        check("load_inc.const", {16'h0, out}, 32'h0033);

        // Random command mix.
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 5),
                 16'($urandom), ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset between edges.
        step("pre_clr", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        while (m_q.size() > 0) step("pre_drain", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 3; k++) step("pre_call", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0500 + 16'(k), 1'b0);
        check("pre_rst.depth", {28'h0, depth}, 32'd3);
        #3;
        rst = 1'b1;
        #1;
        m_pc = 16'h0000;
        m_q.delete();
        m_err = 1'b0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst_ret", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("post_rst_ret.err", {31'h0, err}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
